// File: rtl/node_stream_pkg.sv
// Shared types and widths for the node position streamer.
// Checksum beat is enabled by defining NODE_STREAM_CHECKSUM_EN.
package node_stream_pkg;
   localparam int COORD_W_DEF = 32;
   localparam int FRAME_CNT_W = 16;
   localparam int OVR_CNT_W   = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;
endpackage

// File: rtl/node_snapshot_bank.sv
// Snapshot registers for all node coordinates with an indexed read port.
// With NODE_STREAM_CHECKSUM_EN, index NODE_COUNT reads the XOR of every snapshot entry.
module node_snapshot_bank #(
   parameter  int NODE_COUNT = 5,
   parameter  int COORD_W    = 32,
   localparam int IDX_W      = $clog2(NODE_COUNT + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          capture,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
   input  logic [IDX_W-1:0]              rd_idx,
   output logic [COORD_W-1:0]            rd_x,
   output logic [COORD_W-1:0]            rd_y
);
   logic [COORD_W-1:0] snap_x [NODE_COUNT];
   logic [COORD_W-1:0] snap_y [NODE_COUNT];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NODE_COUNT; i++) begin
            snap_x[i] <= '0;
            snap_y[i] <= '0;
         end
      end else if (capture) begin
         for (int unsigned i = 0; i < NODE_COUNT; i++) begin
            snap_x[i] <= nodes_x[i*COORD_W +: COORD_W];
            snap_y[i] <= nodes_y[i*COORD_W +: COORD_W];
         end
      end
   end

`ifdef NODE_STREAM_CHECKSUM_EN
   logic [COORD_W-1:0] xor_x;
   logic [COORD_W-1:0] xor_y;

   always_comb begin
      xor_x = '0;
      xor_y = '0;
      for (int unsigned i = 0; i < NODE_COUNT; i++) begin
         xor_x = xor_x ^ snap_x[i];
         xor_y = xor_y ^ snap_y[i];
      end
   end
`endif

   always_comb begin
      rd_x = '0;
      rd_y = '0;
      for (int unsigned i = 0; i < NODE_COUNT; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_x = snap_x[i];
            rd_y = snap_y[i];
         end
      end
`ifdef NODE_STREAM_CHECKSUM_EN
      if (rd_idx == IDX_W'(NODE_COUNT)) begin
         rd_x = xor_x;
         rd_y = xor_y;
      end
`endif
   end
endmodule

// File: rtl/node_stream_out.sv
// Snapshots the packed node position bus on start and streams one node per beat over valid/ready.
// Optional trailing XOR checksum beat when NODE_STREAM_CHECKSUM_EN is defined.
module node_stream_out
   import node_stream_pkg::*;
#(
   parameter  int NODE_COUNT = 5,
   parameter  int COORD_W    = COORD_W_DEF,
   localparam int IDX_W      = $clog2(NODE_COUNT + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
   input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
   input  logic                          start,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IDX_W-1:0]              out_idx,
   output logic [COORD_W-1:0]            out_x,
   output logic [COORD_W-1:0]            out_y,
   output logic                          out_last,
   output logic                          busy,
   output logic [FRAME_CNT_W-1:0]        frame_count,
   output logic [OVR_CNT_W-1:0]          overrun_count
);
`ifdef NODE_STREAM_CHECKSUM_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT);
`else
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);
`endif
   localparam logic FIRST_IS_LAST = (LAST_IDX == '0);

   state_t             state;
   logic               capture;
   logic               final_xfer;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;

   // A new snapshot is taken from IDLE, or on the final transfer so back-to-back frames have no bubble.
   assign final_xfer = (state == ST_SEND) && out_ready && out_last;
   assign capture    = start && ((state == ST_IDLE) || final_xfer);

   node_snapshot_bank #(
      .NODE_COUNT (NODE_COUNT),
      .COORD_W    (COORD_W)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .nodes_x (nodes_x),
      .nodes_y (nodes_y),
      .rd_idx  (out_idx),
      .rd_x    (rd_x),
      .rd_y    (rd_y)
   );

   assign out_x = out_valid ? rd_x : '0;
   assign out_y = out_valid ? rd_y : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         out_valid     <= 1'b0;
         out_idx       <= '0;
         out_last      <= 1'b0;
         busy          <= 1'b0;
         frame_count   <= '0;
         overrun_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_SEND;
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_last  <= FIRST_IS_LAST;
                  busy      <= 1'b1;
               end
            end
            ST_SEND: begin
               if (final_xfer) begin
                  frame_count <= frame_count + FRAME_CNT_W'(1);
                  out_idx     <= '0;
                  if (start) begin
                     out_last <= FIRST_IS_LAST;
                  end else begin
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                  end
               end else begin
                  if (out_ready) begin
                     out_idx  <= out_idx + IDX_W'(1);
                     out_last <= ((out_idx + IDX_W'(1)) == LAST_IDX);
                  end
                  if (start && (overrun_count != '1)) begin
                     overrun_count <= overrun_count + OVR_CNT_W'(1);
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               out_idx   <= '0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
